// File: rtl/branch_pkg.sv
// Shared types and constants for the EX-stage branch resolution block.
// Holds the squash FSM encoding, the predictor counter encoding and the PC step.
package branch_pkg;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } state_t;

   // 2-bit saturating predictor counter encoding, used by the predictor side
   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr2_t;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'b00,
      CLS_BRANCH = 2'b01,
      CLS_JAL    = 2'b10,
      CLS_JALR   = 2'b11
   } cls_t;

   localparam logic [31:0] PC_STEP = 32'd4;

   // jalr outranks jal, which outranks a conditional branch
   function automatic cls_t classify(input logic is_branch, input logic is_jal,
                                     input logic is_jalr);
      cls_t c;
      if (is_jalr) begin
         c = CLS_JALR;
      end else if (is_jal) begin
         c = CLS_JAL;
      end else if (is_branch) begin
         c = CLS_BRANCH;
      end else begin
         c = CLS_NONE;
      end
      return c;
   endfunction

endpackage

// File: rtl/branch_resolve_ctrl_sat_counter.sv
// Saturating event counter; sticks at all-ones and reads as zero while reset is held.
module sat_event_counter
   import branch_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_r;

   // Count qualified events, holding at the top value
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= '0;
      end else if (inc && (count_r != '1)) begin
         count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = reset ? '0 : count_r;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves EX-stage control transfers, drives predictor update strobes and
// fetch redirects, and blanks EX for a few cycles after each redirect.
module branch_resolve_ctrl
   import branch_pkg::*;
#(
   parameter int SQUASH_CYC = 1,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_is_jal,
   input  logic             ex_is_jalr,
   input  logic             ex_bcond,
   input  logic [31:0]      ex_pc,
   input  logic [31:0]      ex_target,
   input  logic [31:0]      ex_pred_pc,
   input  logic             stall_in,
   output logic             update_B_history,
   output logic             update_B_target,
   output logic             actual_taken,
   output logic [31:0]      actual_pc,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYC);

   state_t      state_r;
   state_t      state_next_s;
   logic [2:0]  sq_cnt_r;
   logic [2:0]  sq_cnt_next_s;

   cls_t        cls_s;
   logic        resolve_s;
   logic        taken_s;
   logic [31:0] next_pc_s;
   logic        mispred_s;

   // Resolution datapath; reset and squash both veto the event
   always_comb begin
      cls_s     = classify(ex_is_branch, ex_is_jal, ex_is_jalr);
      resolve_s = !reset && ex_valid && (cls_s != CLS_NONE) && !stall_in
                  && (state_r == RUN);
      taken_s   = (cls_s == CLS_JAL) || (cls_s == CLS_JALR)
                  || ((cls_s == CLS_BRANCH) && ex_bcond);
      next_pc_s = taken_s ? ex_target : (ex_pc + PC_STEP);
      mispred_s = resolve_s && (next_pc_s != ex_pred_pc);
   end

   // State and squash counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= RUN;
         sq_cnt_r <= 3'd0;
      end else begin
         state_r  <= state_next_s;
         sq_cnt_r <= sq_cnt_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s  = state_r;
      sq_cnt_next_s = sq_cnt_r;
      case (state_r)
         RUN: begin
            if (mispred_s) begin
               state_next_s  = SQUASH;
               sq_cnt_next_s = SQ_LOAD;
            end else begin
               state_next_s  = RUN;
               sq_cnt_next_s = 3'd0;
            end
         end
         SQUASH: begin
            sq_cnt_next_s = sq_cnt_r - 3'd1;
            if (sq_cnt_r <= 3'd1) begin
               state_next_s  = RUN;
               sq_cnt_next_s = 3'd0;
            end else begin
               state_next_s  = SQUASH;
            end
         end
         default: begin
            state_next_s  = RUN;
            sq_cnt_next_s = 3'd0;
         end
      endcase
   end

   // Strobe outputs, all single-cycle and only on a resolve event
   always_comb begin
      update_B_history = 1'b0;
      update_B_target  = 1'b0;
      actual_taken     = 1'b0;
      actual_pc        = 32'd0;
      redirect_valid   = 1'b0;
      redirect_pc      = 32'd0;
      flush_if_id      = 1'b0;
      flush_id_ex      = 1'b0;
      if (resolve_s) begin
         actual_taken     = taken_s;
         actual_pc        = next_pc_s;
         update_B_history = (cls_s == CLS_BRANCH);
         update_B_target  = taken_s;
         if (mispred_s) begin
            redirect_valid = 1'b1;
            redirect_pc    = next_pc_s;
            flush_if_id    = 1'b1;
            flush_id_ex    = 1'b1;
         end else begin
            redirect_valid = 1'b0;
         end
      end else begin
         actual_taken = 1'b0;
      end
   end

   sat_event_counter #(.CNT_W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (resolve_s),
      .count (branch_cnt)
   );

   sat_event_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (mispred_s),
      .count (mispred_cnt)
   );

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 Parameter SQUASH_CYC, default 1, number of cycles after a redirect during which EX resolutions are ignored (1..7).
REQ-002 Parameter CNT_W, default 32, width of the performance counters.
REQ-003 Clock and reset: clk and reset; reset is synchronous and active-high; clk is the clock.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 ex_valid  in  1  the EX stage holds a real (non-bubble) instruction.
REQ-007 ex_is_branch / ex_is_jal / ex_is_jalr  in  1 each  instruction class of the EX-stage instruction.
REQ-008 ex_bcond  in  1  conditional-branch comparison result.
REQ-009 ex_pc  in  32  PC of the EX-stage instruction.
REQ-010 ex_target  in  32  computed taken target (the PC-relative target, or the JALR target with bit 0 cleared).
REQ-011 ex_pred_pc  in  32  next-PC predicted at fetch for this instruction.
REQ-012 stall_in  in  1  pipeline stall; the EX instruction is held.
REQ-013 update_B_history  out  1  PHT/BHSR update strobe to the predictor.
REQ-014 update_B_target  out  1  tag/BTB update strobe to the predictor.
REQ-015 actual_taken  out  1  resolved direction.
REQ-016 actual_pc  out  32  resolved next PC.
REQ-017 redirect_valid / redirect_pc  out  1 / 32  PC override for fetch.
REQ-018 flush_if_id / flush_id_ex  out  1 each  squash of the younger pipeline registers.
REQ-019 branch_cnt / mispred_cnt  out  CNT_W each  counts of resolved control transfers and of mispredictions.

Function
REQ-020 A resolve event occurs when all of the following hold: ex_valid=1; at least one class bit is set; stall_in=0; state=RUN.
REQ-021 Class priority when more than one class bit is set: jalr, then jal, then branch.
REQ-022 actual_taken = jal | jalr | (branch & ex_bcond); it is valid in the resolve cycle and 0 otherwise.
REQ-023 actual_pc = actual_taken ? ex_target : ex_pc+4; the addition wraps modulo 2^32, so 0xFFFFFFFC+4 gives 0.
REQ-024 Misprediction = (actual_pc != ex_pred_pc), evaluated only on a resolve event.
REQ-025 Timing of strobes: update_B_history, update_B_target, redirect and flush are combinational, same cycle as the resolve event, single-cycle pulses.
REQ-026 update_B_history fires on every resolve event of class branch, whether taken or not.
REQ-027 update_B_target fires on every resolve event with actual_taken=1, for any class.
REQ-028 On a misprediction, all of the following happen in the same cycle: redirect_valid=1; redirect_pc=actual_pc; flush_if_id=1; flush_id_ex=1.
REQ-029 FSM states: RUN and SQUASH.
REQ-030 FSM transition RUN to SQUASH: on a misprediction, loading the squash counter with SQUASH_CYC.
REQ-031 FSM in SQUASH: the counter decrements each cycle and the FSM returns to RUN when it reaches 0; all strobes stay 0 and EX inputs are ignored.
REQ-032 stall_in=1 suppresses the event; the event is taken in the first cycle with stall_in=0 and is never taken twice.
REQ-033 branch_cnt increments on each resolve event, and mispred_cnt increments on each misprediction.
REQ-034 Both counters saturate at all-ones and never wrap.

Reset
REQ-035 Reset values: state=RUN, squash counter=0, both perf counters=0.
REQ-036 While reset is asserted, every output is 0.
REQ-037 Reset asserted in SQUASH returns the FSM to RUN on the next edge.
REQ-038 Reset has priority over a simultaneous resolve event; no strobe is issued.

Structure
REQ-039 Package branch_pkg holds: the FSM state encoding (RUN, SQUASH); the 2-bit counter encodings (strong_NT..strong_T); the PC_STEP constant (4).
REQ-040 Sub-module sat_event_counter (CNT_W parameter, inc input, saturating output) is instantiated twice, once for each perf counter.
REQ-041 The block contains no BTB or PHT storage; it only drives the predictor update ports.

Verification
REQ-042 Scenario: branch, ex_pc=0x100, ex_bcond=1, ex_target=0x80, ex_pred_pc=0x80 -> update_B_history=1, update_B_target=1, redirect_valid=0, branch_cnt=1.
REQ-043 Scenario: branch, ex_pc=0x100, ex_bcond=0, ex_pred_pc=0x80 -> actual_pc=0x104, redirect_pc=0x104, both flushes=1, update_B_target=0, mispred_cnt=1, then 1 cycle in SQUASH.
REQ-044 Scenario: jalr, ex_target=0x2000, ex_pred_pc=0x1004, SQUASH_CYC=3, valid branch in EX in the next 3 cycles -> exactly 1 redirect, no strobes for 3 cycles, RUN on cycle 4.
REQ-045 Scenario: branch held with stall_in=1 for 4 cycles, then released -> exactly one update_B_history pulse, in the release cycle.
REQ-046 Scenario: counters preloaded by forcing to all-ones, followed by a mispredicting jal -> both counters remain all-ones.
REQ-047 Scenario: reset asserted during SQUASH -> next cycle state=RUN, counters=0, a correctly predicted branch issues strobes normally.
